// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM states and {way,set} sizing/packing helpers for the replacement requester
package cache_pkg;
    typedef enum logic [2:0] {IDLE, LOOKUP, VICTIM_WAIT, WRITEBACK, FILL, UPDATE} state_t;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int bw_set(input int blocks, input int ways);
        return clog2(blocks) - clog2(ways);
    endfunction

    function automatic int unsigned pack_ws(input int unsigned way, input int unsigned set_idx, input int set_bits);
        return (way << set_bits) | set_idx;
    endfunction

    function automatic int unsigned way_of(input int unsigned ws, input int set_bits);
        return ws >> set_bits;
    endfunction
endpackage

// File: rtl/cache_tag_store.sv
// cache_tag_store: tag/valid/dirty arrays with a combinational set lookup and one write port
module cache_tag_store #(
    parameter int WAYS = 2,
    parameter int SW = 2,
    parameter int GW = 1,
    parameter int BW_TAG = 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SW-1:0]     set_idx,
    input  logic [BW_TAG-1:0] tag,
    output logic              hit,
    output logic [GW-1:0]     hit_way,
    output logic              free,
    output logic [GW-1:0]     free_way,
    input  logic [GW-1:0]     rd_way,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [BW_TAG-1:0] rd_tag,
    input  logic              wr_en,
    input  logic [GW-1:0]     wr_way,
    input  logic              wr_dirty,
    input  logic              ds_en,
    input  logic [GW-1:0]     ds_way
);
    localparam int N = 1 << (SW + GW);

    logic [N-1:0]      valid;
    logic [N-1:0]      dirty;
    logic [BW_TAG-1:0] tags [N];

    // descending scan so the lowest-index invalid way wins
    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        free = 1'b0;
        free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[{set_idx, GW'(w)}] && tags[{set_idx, GW'(w)}] == tag) begin
                hit = 1'b1;
                hit_way = GW'(w);
            end
            if (!valid[{set_idx, GW'(w)}]) begin
                free = 1'b1;
                free_way = GW'(w);
            end
        end
    end

    assign rd_valid = valid[{set_idx, rd_way}];
    assign rd_dirty = dirty[{set_idx, rd_way}];
    assign rd_tag = tags[{set_idx, rd_way}];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            dirty <= '0;
        end else if (wr_en) begin
            valid[{set_idx, wr_way}] <= 1'b1;
            dirty[{set_idx, wr_way}] <= wr_dirty;
        end else if (ds_en) begin
            dirty[{set_idx, ds_way}] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) tags[{set_idx, wr_way}] <= tag;
    end
endmodule

// File: rtl/n_set_cache_replacement_requester.sv
// n_set_cache_replacement_requester: looks up core block requests, reports hit/miss to the
// replacement policy, and runs the writeback/fill sequence for the chosen victim.
module n_set_cache_replacement_requester
    import cache_pkg::*;
#(
    parameter int CACHE_BLOCK_CAPACITY = 8,
    parameter int CACHE_SET_SIZE = 2,
    parameter int BW_ADDR = 24,
    localparam int BW_CACHE_CAPACITY = clog2(CACHE_BLOCK_CAPACITY)
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         core_req_i,
    input  logic                         core_wren_i,
    input  logic [BW_ADDR-1:0]           core_addr_i,
    output logic                         core_ready_o,
    output logic                         core_done_o,
    output logic [BW_CACHE_CAPACITY-1:0] core_cache_addr_o,
    output logic                         policy_hit_o,
    output logic                         policy_miss_o,
    output logic [BW_CACHE_CAPACITY-1:0] policy_addr_o,
    input  logic                         policy_done_i,
    input  logic [BW_CACHE_CAPACITY-1:0] policy_addr_i,
    output logic                         mem_req_o,
    output logic                         mem_wb_o,
    output logic [BW_ADDR-1:0]           mem_addr_o,
    input  logic                         mem_ack_i
);
    localparam int BW_GRP = clog2(CACHE_SET_SIZE);
    localparam int BW_SET = bw_set(CACHE_BLOCK_CAPACITY, CACHE_SET_SIZE);
    localparam int BW_TAG = BW_ADDR - BW_SET;
    localparam int SW = (BW_SET > 0) ? BW_SET : 1;
    localparam int GW = (BW_GRP > 0) ? BW_GRP : 1;

    state_t state, state_n;
    logic [BW_ADDR-1:0]           addr_q;
    logic                         wren_q;
    logic [GW-1:0]                way_q;
    logic [SW-1:0]                set_idx;
    logic [BW_TAG-1:0]            tag;
    logic                         hit, free, rd_valid, rd_dirty;
    logic [GW-1:0]                hit_way, free_way, rd_way, victim_way;
    logic [BW_TAG-1:0]            rd_tag;
    logic [BW_CACHE_CAPACITY-1:0] hit_addr, miss_addr, victim_addr;

    assign set_idx = (BW_SET > 0) ? addr_q[SW-1:0] : '0;
    assign tag = BW_TAG'(addr_q >> BW_SET);
    assign victim_way = GW'(way_of(32'(policy_addr_i), BW_SET));
    assign rd_way = (state == VICTIM_WAIT) ? victim_way : way_q;
    assign hit_addr = BW_CACHE_CAPACITY'(pack_ws(32'(hit_way), 32'(set_idx), BW_SET));
    assign miss_addr = BW_CACHE_CAPACITY'(pack_ws(0, 32'(set_idx), BW_SET));
    assign victim_addr = BW_CACHE_CAPACITY'(pack_ws(32'(way_q), 32'(set_idx), BW_SET));

    cache_tag_store #(
        .WAYS(CACHE_SET_SIZE),
        .SW(SW),
        .GW(GW),
        .BW_TAG(BW_TAG)
    ) u_store (
        .clk(clock_i),
        .rst(reset_i),
        .set_idx(set_idx),
        .tag(tag),
        .hit(hit),
        .hit_way(hit_way),
        .free(free),
        .free_way(free_way),
        .rd_way(rd_way),
        .rd_valid(rd_valid),
        .rd_dirty(rd_dirty),
        .rd_tag(rd_tag),
        .wr_en(state == UPDATE),
        .wr_way(way_q),
        .wr_dirty(wren_q),
        .ds_en(state == LOOKUP && hit && wren_q),
        .ds_way(hit_way)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        core_ready_o = 1'b0;
        mem_req_o = 1'b0;
        mem_wb_o = 1'b0;
        mem_addr_o = '0;
        case (state)
            IDLE: begin
                core_ready_o = 1'b1;
                state_n = core_req_i ? LOOKUP : IDLE;
            end
            LOOKUP: state_n = hit ? IDLE : free ? FILL : VICTIM_WAIT;
            VICTIM_WAIT: state_n = !policy_done_i ? VICTIM_WAIT : (rd_valid && rd_dirty) ? WRITEBACK : FILL;
            WRITEBACK: begin
                mem_req_o = 1'b1;
                mem_wb_o = 1'b1;
                mem_addr_o = (BW_ADDR'(rd_tag) << BW_SET) | BW_ADDR'(set_idx);
                state_n = mem_ack_i ? FILL : WRITEBACK;
            end
            FILL: begin
                mem_req_o = 1'b1;
                mem_addr_o = addr_q;
                state_n = mem_ack_i ? UPDATE : FILL;
            end
            UPDATE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // pulses and addresses are registered so policy/core see glitch-free values
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            addr_q <= '0;
            wren_q <= 1'b0;
            way_q <= '0;
            policy_hit_o <= 1'b0;
            policy_miss_o <= 1'b0;
            policy_addr_o <= '0;
            core_done_o <= 1'b0;
            core_cache_addr_o <= '0;
        end else begin
            policy_hit_o <= 1'b0;
            policy_miss_o <= 1'b0;
            core_done_o <= 1'b0;
            if (state == IDLE && core_req_i) begin
                addr_q <= core_addr_i;
                wren_q <= core_wren_i;
            end
            if (state == LOOKUP) begin
                policy_hit_o <= hit;
                policy_miss_o <= !hit;
                policy_addr_o <= hit ? hit_addr : miss_addr;
                core_done_o <= hit;
                core_cache_addr_o <= hit ? hit_addr : core_cache_addr_o;
                way_q <= free_way;
            end
            if (state == VICTIM_WAIT && policy_done_i) way_q <= victim_way;
            if (state == UPDATE) begin
                core_done_o <= 1'b1;
                core_cache_addr_o <= victim_addr;
            end
        end
    end
endmodule
